// File: rtl/mem_bus_unit.sv
// mem_bus_unit: round-robin multi-port Avalon-MM bus master with waitrequest stalling.
// Define MEM_BUS_TIMEOUT_EN to build the waitrequest watchdog (TIMEOUT_CYCLES).
module mem_bus_unit #(
    parameter int N_PORTS        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic [N_PORTS-1:0]            req_i,
    input  logic [N_PORTS-1:0]            we_i,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [N_PORTS*2-1:0]          size_i,
    input  logic [N_PORTS-1:0]            signed_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [N_PORTS-1:0]            done_o,
    output logic                          err_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          busy_o,
    output logic [ADDR_WIDTH-1:0]         address,
    output logic                          read,
    output logic                          write,
    output logic [DATA_WIDTH-1:0]         writedata,
    output logic [DATA_WIDTH/8-1:0]       byteenable,
    input  logic                          waitrequest,
    input  logic [DATA_WIDTH-1:0]         readdata
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(LANES);
    localparam int GW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [GW-1:0] LAST_PORT = GW'(N_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_q, last_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
    logic [15:0]           tmo_q, tmo_d;
`endif

    logic                  found;
    logic [GW-1:0]         cand;
    logic [GW-1:0]         pick;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [1:0]            pick_size;
    logic                  bad;
    logic [LW-1:0]         lane;
    logic [LW+2:0]         shamt;
    logic [LANES-1:0]      be_ones;

    assign lane  = addr_q[LW-1:0];
    assign shamt = {lane, 3'b000};

    // Right-justify the addressed lanes, keep 8*2^sz bits, then extend.
    function automatic logic [DATA_WIDTH-1:0] extend(
        input logic [DATA_WIDTH-1:0] d,
        input logic [LW+2:0]         sh,
        input logic [1:0]            sz,
        input logic                  sg
    );
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] top;
        logic                  sbit;
        s    = d >> sh;
        mask = (DATA_WIDTH'(1) << (7'd8 << sz)) - DATA_WIDTH'(1);
        top  = mask ^ (mask >> 1);
        sbit = sg & (|(s & top));
        return (s & mask) | (sbit ? ~mask : '0);
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        found   = 1'b0;
        cand    = last_q;
        pick    = last_q;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = GW'((int'(last_q) + i) % N_PORTS);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        pick_addr = addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
        pick_size = size_i[int'(pick)*2 +: 2];
        bad       = 1'b0;
        unique case (pick_size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = pick_addr[0];
            2'd2:    bad = |pick_addr[1:0];
            default: bad = (DATA_WIDTH < 64) || (|pick_addr[2:0]);
        endcase

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    we_d    = we_i[pick];
                    addr_d  = pick_addr;
                    size_d  = pick_size;
                    sgn_d   = signed_i[pick];
                    wdata_d = wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    err_d   = bad;
                    state_d = bad ? DONE : BUS;
`ifdef MEM_BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    if (!we_q) begin
                        rdata_d = extend(readdata, shamt, size_q, sgn_q);
                    end
                    state_d = DONE;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 16'd1;
                    if (int'(tmo_q) + 1 >= TIMEOUT_CYCLES) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be_ones    = LANES'((16'd1 << (5'd1 << size_q)) - 16'd1);
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        done_o     = '0;
        busy_o     = (state_q != IDLE);
        err_o      = (state_q == DONE) && err_q;
        rdata_o    = rdata_q;
        if (state_q == BUS) begin
            read       = !we_q;
            write      = we_q;
            address    = {addr_q[ADDR_WIDTH-1:LW], LW'(0)};
            writedata  = wdata_q << shamt;
            byteenable = be_ones << lane;
        end
        if (state_q == DONE) begin
            done_o[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
            last_q  <= LAST_PORT;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule
